// File: rtl/sq_accum.sv
// sq_accum: streaming sum-of-squares accumulator, one multi-lane beat per cycle, one result pulse per vector.
//   in:  clk, nrst (async, active-low), in_valid, in_last, in_keep[LANES], in_data[LANES*ELEM_W], in_id[id_width]
//   out: dot_sum[32] (saturated at 0x7FFF_FFFF), id_out, valid_out (1-cycle pulse), sat_out
module sq_accum #(
  parameter int ELEM_W   = 8,
  parameter int LANES    = 4,
  parameter int id_width = 20
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [LANES-1:0]          in_keep,
  input  logic [LANES*ELEM_W-1:0]   in_data,
  input  logic [id_width-1:0]       in_id,
  output logic [31:0]               dot_sum,
  output logic [id_width-1:0]       id_out,
  output logic                      valid_out,
  output logic                      sat_out
);
  localparam int SQ_W  = 2 * ELEM_W;
  localparam int SUM_W = SQ_W + $clog2(LANES);
  // one bit of headroom over both the 31-bit accumulator and the widest beat sum
  localparam int ACC_W = (SUM_W > 31 ? SUM_W : 31) + 1;
  localparam logic [ACC_W-1:0] MAX = ACC_W'(32'h7FFF_FFFF);
  logic                first;
  logic [SQ_W-1:0]     sq [LANES];
  logic [SQ_W-1:0]     s1_sq [LANES];
  logic                s1_valid, s1_last, s1_first;
  logic [id_width-1:0] s1_id;
  logic [SUM_W-1:0]    beat_sum, s2_sum;
  logic                s2_valid, s2_last, s2_first;
  logic [id_width-1:0] s2_id;
  logic [30:0]         acc, nacc, fin_sum;
  logic                sat, nsat, fin_sat, fin_valid;
  logic [id_width-1:0] cur_id, nid, fin_id;
  logic [ACC_W-1:0]    total;
  for (genvar i = 0; i < LANES; i++) begin : g_sq
    logic signed [ELEM_W-1:0] d;
    logic signed [SQ_W-1:0]   p;
    assign d     = in_data[i*ELEM_W +: ELEM_W];
    // the most negative element squared is 2^(2*ELEM_W-2), still positive in SQ_W bits
    assign p     = d * d;
    assign sq[i] = in_keep[i] ? $unsigned(p) : '0;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) first <= 1'b1;
    else if (in_valid) first <= in_last;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_first <= 1'b0;
      s1_id    <= '0;
      for (int i = 0; i < LANES; i++) s1_sq[i] <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_last  <= in_valid & in_last;
      s1_first <= in_valid & first;
      if (in_valid & first) s1_id <= in_id;
      for (int i = 0; i < LANES; i++) s1_sq[i] <= sq[i];
    end
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) beat_sum = beat_sum + SUM_W'(s1_sq[i]);
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_first <= 1'b0;
      s2_id    <= '0;
      s2_sum   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_first <= s1_first;
      s2_id    <= s1_id;
      s2_sum   <= beat_sum;
    end
  // a first beat starts from zero and a clean sat flag, so back-to-back vectors never mix
  always_comb begin
    total = (s2_first ? '0 : ACC_W'(acc)) + ACC_W'(s2_sum);
    nsat  = (~s2_first & sat) | (total > MAX);
    nacc  = nsat ? 31'h7FFF_FFFF : total[30:0];
    nid   = s2_first ? s2_id : cur_id;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      acc       <= '0;
      sat       <= 1'b0;
      cur_id    <= '0;
      fin_valid <= 1'b0;
      fin_sum   <= '0;
      fin_sat   <= 1'b0;
      fin_id    <= '0;
    end else begin
      fin_valid <= s2_valid & s2_last;
      if (s2_valid) begin
        cur_id <= nid;
        acc    <= s2_last ? '0 : nacc;
        sat    <= ~s2_last & nsat;
        if (s2_last) begin
          fin_sum <= nacc;
          fin_sat <= nsat;
          fin_id  <= nid;
        end
      end
    end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      valid_out <= 1'b0;
      dot_sum   <= '0;
      sat_out   <= 1'b0;
      id_out    <= '0;
    end else begin
      valid_out <= fin_valid;
      if (fin_valid) begin
        dot_sum <= {1'b0, fin_sum};
        sat_out <= fin_sat;
        id_out  <= fin_id;
      end
    end
endmodule

// File: tb/tb_sq_accum.sv
// tb_sq_accum: randomized and directed check of sq_accum against a per-vector arithmetic model.
module tb_sq_accum;
  localparam int EW = 16;
  localparam int LN = 4;
  localparam int IW = 20;
  localparam longint MAXL = 64'h7FFF_FFFF;
  logic            clk = 1'b0, nrst = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [LN-1:0]   in_keep = '0;
  logic [LN*EW-1:0] in_data = '0;
  logic [IW-1:0]   in_id = '0;
  logic [31:0]     dot_sum;
  logic [IW-1:0]   id_out;
  logic            valid_out, sat_out;
  sq_accum #(.ELEM_W(EW), .LANES(LN), .id_width(IW)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_last(in_last), .in_keep(in_keep),
    .in_data(in_data), .in_id(in_id), .dot_sum(dot_sum), .id_out(id_out),
    .valid_out(valid_out), .sat_out(sat_out)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    int          due;
    logic [31:0] sum;
    logic [IW-1:0] id;
    logic        sat;
  } exp_t;
  exp_t q[$];
  int n_vec = 0, n_err = 0;
  longint m_sum = 0;
  logic [IW-1:0] m_id = '0;
  bit m_first = 1'b1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // drive one beat; the model keeps the exact sum of squares and clamps only at the end
  task automatic beat(input int d0, d1, d2, d3, input logic [3:0] keep, input logic last,
                      input logic [IW-1:0] id);
    int d[4];
    exp_t e;
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < LN; i++) in_data[i*EW +: EW] = d[i][EW-1:0];
    in_keep  = keep;
    in_last  = last;
    in_id    = id;
    in_valid = 1'b1;
    if (m_first) begin
      m_sum = 0;
      m_id  = id;
    end
    for (int i = 0; i < LN; i++) if (keep[i]) m_sum += longint'(d[i]) * longint'(d[i]);
    if (last) begin
      e.due = cyc + 4;
      e.sat = m_sum > MAXL;
      e.sum = e.sat ? 32'h7FFF_FFFF : 32'(m_sum);
      e.id  = m_id;
      q.push_back(e);
    end
    m_first = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    nrst = 1'b0;
    q.delete();
    m_first = 1'b1;
    m_sum = 0;
    idle(2);
    nrst = 1'b1;
  endtask
  always @(negedge clk) begin
    bit e;
    if (!nrst) begin
      check("rst_valid", 64'(valid_out), 0);
      check("rst_sum", 64'(dot_sum), 0);
      check("rst_id", 64'(id_out), 0);
      check("rst_sat", 64'(sat_out), 0);
    end else begin
      e = (q.size() > 0) && (q[0].due == cyc);
      check("valid_out", 64'(valid_out), 64'(e));
      if (e) begin
        check("dot_sum", 64'(dot_sum), 64'(q[0].sum));
        check("id_out", 64'(id_out), 64'(q[0].id));
        check("sat_out", 64'(sat_out), 64'(q[0].sat));
        void'(q.pop_front());
      end
    end
  end
  initial begin
    int big;
    int r[4];
    idle(3);
    nrst = 1'b1;
    idle(2);
    beat(1, 2, 3, 4, 4'b1111, 1, 20'h000A5);
    idle(6);
    beat(-128, -128, -128, -128, 4'b1111, 0, 7);
    idle(2);
    beat(-128, -128, -128, -128, 4'b1111, 0, 9);
    idle(2);
    beat(-128, -128, -128, -128, 4'b1111, 1, 9);
    idle(6);
    beat(5, 5, 7, 7, 4'b0011, 1, 3);
    beat(9, 9, 9, 9, 4'b0000, 1, 5);
    idle(6);
    beat(1, 1, 1, 1, 4'b1111, 0, 1);
    beat(1, 1, 1, 1, 4'b1111, 1, 1);
    beat(2, 0, 0, 0, 4'b1111, 1, 2);
    beat(3, 0, 0, 0, 4'b1111, 1, 3);
    idle(6);
    beat(-32768, -32768, -32768, -32768, 4'b1111, 0, 5);
    beat(1, 0, 0, 0, 4'b1111, 1, 5);
    beat(1, 0, 0, 0, 4'b1111, 1, 6);
    idle(6);
    beat(3, 3, 3, 3, 4'b1111, 0, 6);
    beat(3, 3, 3, 3, 4'b1111, 0, 6);
    do_reset();
    beat(1, 0, 0, 0, 4'b1111, 1, 4);
    idle(6);
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      if ($urandom_range(0, 3) == 0) idle(1);
      else begin
        big = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < 4; i++)
          r[i] = big ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 510)) - 255;
        beat(r[0], r[1], r[2], r[3], 4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0),
             IW'($urandom));
      end
    end
    beat(0, 0, 0, 0, 4'b0000, 1, 0);
    idle(8);
    check("drain", 64'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
